// File: rtl/key_debounce_if.sv
// Key debouncer signal bundle: raw pushbutton levels in,
// debounced level plus press/release strobes out.
interface key_debounce_if #(
  parameter int NUM_KEYS = 2
);
  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_db;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;

  modport master (
    output key_raw,
    input  key_db,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_raw,
    output key_db,
    output key_press,
    output key_release
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key two-flop synchroniser and four-state debouncer.
// key_db feeds the key PIO in_port; strobes serve fabric logic.
module key_debounce #(
  parameter int NUM_KEYS      = 2,
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = 19
) (
  input  logic           clk,
  input  logic           reset_n,
  key_debounce_if.slave  kif
);

  if (STABLE_CYCLES < 2 ||
      (64'd1 << CNT_W) <= 64'(STABLE_CYCLES)) begin : g_bad_cfg
    $error("key_debounce: STABLE_CYCLES out of range for CNT_W");
  end

  typedef enum logic [1:0] {
    S_HIGH,
    S_WAIT_LOW,
    S_LOW,
    S_WAIT_HIGH
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] db_q;
  logic [NUM_KEYS-1:0] press_q;
  logic [NUM_KEYS-1:0] release_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= kif.key_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state        <= S_HIGH;
        cnt          <= '0;
        db_q[i]      <= 1'b1;
        press_q[i]   <= 1'b0;
        release_q[i] <= 1'b0;
      end else begin
        press_q[i]   <= 1'b0;
        release_q[i] <= 1'b0;
        unique case (state)
          S_HIGH: begin
            if (!sync2[i]) begin
              state <= S_WAIT_LOW;
              cnt   <= ONE;
            end else begin
              cnt   <= '0;
            end
          end
          S_WAIT_LOW: begin
            // one sample back at the old level drops all progress
            if (sync2[i]) begin
              state <= S_HIGH;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state      <= S_LOW;
              cnt        <= '0;
              db_q[i]    <= 1'b0;
              press_q[i] <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          S_LOW: begin
            if (sync2[i]) begin
              state <= S_WAIT_HIGH;
              cnt   <= ONE;
            end else begin
              cnt   <= '0;
            end
          end
          S_WAIT_HIGH: begin
            if (!sync2[i]) begin
              state <= S_LOW;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state        <= S_HIGH;
              cnt          <= '0;
              db_q[i]      <= 1'b1;
              release_q[i] <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        endcase
      end
    end
  end

  assign kif.key_db      = db_q;
  assign kif.key_press   = press_q;
  assign kif.key_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: vector tables, corner
// sequences and random stimulus against a sample-history model.
module tb_key_debounce;

  localparam int NK = 2;
  localparam int SC = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  key_debounce_if #(.NUM_KEYS(NK)) kif ();

  key_debounce #(
    .NUM_KEYS(NK),
    .STABLE_CYCLES(SC),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .kif(kif.slave)
  );

  typedef struct {
    logic [NK-1:0] raw;
    logic [NK-1:0] db;
    logic [NK-1:0] pr;
    logic [NK-1:0] rl;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Model: pipeline of two raw samples, then a history of the last
  // SC synchronised samples; a level is accepted when all SC differ
  // from the current debounced level.
  logic [NK-1:0] m_s1, m_s2, m_db, m_pr, m_rl;
  logic [NK-1:0] hist[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({kif.key_db, kif.key_press, kif.key_release});
  endfunction

  task automatic m_reset();
    m_s1 = '1;
    m_s2 = '1;
    m_db = '1;
    m_pr = '0;
    m_rl = '0;
    hist.delete();
  endtask

  task automatic m_edge(input logic [NK-1:0] raw);
    logic [NK-1:0] smp;
    bit all_new;
    smp  = m_s2;
    m_s2 = m_s1;
    m_s1 = raw;
    hist.push_back(smp);
    if (hist.size() > SC) hist.delete(0);
    m_pr = '0;
    m_rl = '0;
    for (int i = 0; i < NK; i++) begin
      if (hist.size() == SC) begin
        all_new = 1'b1;
        foreach (hist[j]) if (hist[j][i] == m_db[i]) all_new = 1'b0;
        if (all_new) begin
          if (m_db[i]) m_pr[i] = 1'b1;
          else         m_rl[i] = 1'b1;
          m_db[i] = ~m_db[i];
        end
      end
    end
  endtask

  task automatic step(input logic [NK-1:0] raw);
    kif.key_raw = raw;
    @(posedge clk);
    m_edge(raw);
    #1;
    chk("model", outs(), 32'({m_db, m_pr, m_rl}));
    @(negedge clk);
  endtask

  task automatic do_reset(input int cyc);
    @(negedge clk);
    reset_n = 1'b0;
    m_reset();
    #1;
    chk("reset_state", outs(), 32'({2'b11, 2'b00, 2'b00}));
    repeat (cyc) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_table(input string nm, input vec_t tv[$]);
    foreach (tv[k]) begin
      step(tv[k].raw);
      chk(nm, outs(), 32'({tv[k].db, tv[k].pr, tv[k].rl}));
    end
  endtask

  initial begin
    vec_t t_idle[$];
    vec_t t_press[$];
    vec_t t_bounce[$];
    logic [NK-1:0] bseq;
    logic [NK-1:0] r;
    int hit;

    for (int k = 0; k < 20; k++)
      t_idle.push_back('{2'b11, 2'b11, 2'b00, 2'b00});
    for (int k = 1; k <= 8; k++)
      t_press.push_back('{2'b10,
                          (k >= 6) ? 2'b10 : 2'b11,
                          (k == 6) ? 2'b01 : 2'b00,
                          2'b00});
    bseq = 2'b00;
    for (int k = 1; k <= 12; k++) begin
      bseq[0] = (k == 4);
      t_bounce.push_back('{{1'b1, bseq[0]},
                           (k >= 10) ? 2'b10 : 2'b11,
                           (k == 10) ? 2'b01 : 2'b00,
                           2'b00});
    end

    kif.key_raw = '1;
    m_reset();
    do_reset(3);

    run_table("idle", t_idle);
    run_table("clean_press", t_press);

    repeat (8) step(2'b11);
    run_table("bounce", t_bounce);

    repeat (8) step(2'b00);
    chk("both_low", 32'(kif.key_db), 32'(2'b00));
    for (int k = 1; k <= 8; k++) begin
      step(2'b11);
      if (k == 6)
        chk("rel_both", outs(), 32'({2'b11, 2'b00, 2'b11}));
      else if (k < 6)
        chk("rel_wait", outs(), 32'({2'b00, 2'b00, 2'b00}));
    end

    for (int k = 1; k <= 10; k++) begin
      step((k <= 3) ? 2'b01 : 2'b11);
      chk("glitch", outs(), 32'({2'b11, 2'b00, 2'b00}));
    end

    repeat (3) step(2'b10);
    do_reset(2);
    hit = 0;
    for (int k = 1; k <= 8; k++) begin
      step(2'b10);
      if (kif.key_press[0] && hit == 0) hit = k;
    end
    chk("rst_press_edge", 32'(hit), 32'd6);
    repeat (8) step(2'b11);

    r = '1;
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(5) == 0) r[i] = ~r[i];
      step(r);
      if (k == 400) do_reset(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
